csc_yuv444_to_422: RTL and testbench
====================================

Name: csc_yuv444_to_422

Overview:
- Chroma subsampler sitting directly downstream of the 3x3 colour-space-conversion stage. It consumes YCbCr 4:4:4 (unsigned Y, signed Cb/Cr) plus vs/hs/de timing, and produces 4:2:2 with one luma and one chroma sample per pixel.
- Chroma is taken horizontally in pixel pairs. Cb is carried on the even pixel of each pair and Cr on the odd pixel.
- Optional 2-tap averaging filter; otherwise plain co-sited decimation.

Parameters:
- DATA_WIDTH, 8, bit width of Y, Cb, Cr and all outputs.
- FILTER_EN, 1, 1 = average the pair's chroma, 0 = take the even pixel's chroma (decimate).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rstn  input  1  synchronous active-low reset.
- i_vs  input  1  vertical sync.
- i_hs  input  1  horizontal sync.
- i_de  input  1  data enable; one pixel per cycle while high.
- i_y  input  DATA_WIDTH  luma, unsigned.
- i_cb  input  DATA_WIDTH  Cb, signed two's complement.
- i_cr  input  DATA_WIDTH  Cr, signed two's complement.
- o_vs  output  1  i_vs delayed by 2 cycles.
- o_hs  output  1  i_hs delayed by 2 cycles.
- o_de  output  1  i_de delayed by 2 cycles.
- o_y  output  DATA_WIDTH  luma, unsigned.
- o_c  output  DATA_WIDTH  chroma sample, signed.
- o_c_sel  output  1  0 = o_c is Cb, 1 = o_c is Cr.

Behaviour:
- Reset: synchronous, sampled on the clk rising edge while rstn=0. It clears every output (o_vs, o_hs, o_de, o_y, o_c, o_c_sel) to 0, the phase bit to 0, and all pipeline and pending registers including their valid flags. A reset mid-line drops any pending pixel. The first pixel after reset is treated as even.
- Pipeline:
  - Two register stages: S1 holds the pending even pixel (y, cb, cr, valid); OUT is the output registers plus a held Cr register.
  - vs/hs/de pass through a 2-deep shift register, so o_de is high exactly for the cycles carrying pixels.
- Phase:
  - A 1-bit counter toggles on each cycle with i_de=1.
  - It is forced to 0 on any cycle with i_de=0, so each de-high run starts even.
- Cycle with i_de=1 and phase=0 (even pixel):
  - Capture i_y/i_cb/i_cr into S1 and set valid.
  - If S1 already held a valid pending pixel, that case cannot occur (phase forbids it); no extra handling is required.
- Cycle with i_de=1 and phase=1 (odd pixel):
  - OUT loads o_y = S1.y, o_c = cb_pair, o_c_sel = 0.
  - Simultaneously capture i_y and cr_pair into S1/held-Cr.
  - On the next cycle, OUT loads o_y = odd y, o_c = cr_pair, o_c_sel = 1.
- Pair arithmetic (FILTER_EN=1):
  - cb_pair = (S1.cb + i_cb + 1) >>> 1, with operands sign-extended to DATA_WIDTH+1 bits and the result truncated to DATA_WIDTH.
  - The result is always in range, so no clip is needed.
  - cr_pair is the same formula using Cr.
- FILTER_EN=0: cb_pair = S1.cb and cr_pair = S1.cr (even-pixel co-sited).
- Unpaired pixel (odd-length run): on a cycle with i_de=0 while S1 holds a valid even pixel, OUT loads o_y = S1.y, o_c = S1.cb (unfiltered), o_c_sel = 0. No Cr sample is emitted for it, and S1 valid is cleared.
- Output data (o_y, o_c, o_c_sel) is updated only when a pixel is emitted and otherwise holds its last value. o_vs/o_hs/o_de follow the 2-cycle delay unconditionally.
- Latency: a pixel sampled at edge n appears on the outputs after edge n+2. This holds uniformly for even, odd and unpaired pixels, so o_de stays aligned with the data.
- Back-to-back lines separated by a single de-low cycle must work; the flush and the new even capture do not conflict because they use different registers.

Test Plan:
- Reset: hold rstn=0 for 3 cycles with random inputs -> all outputs 0. Release, then a 4-pixel line -> first output pixel has o_c_sel=0.
- Averaging, FILTER_EN=1: pair Y=(10,20), Cb=(-3,-4), Cr=(100,101) -> o_y=10, o_c=-3, sel=0, then o_y=20, o_c=101, sel=1, appearing 2 cycles after the inputs, with o_de high on both cycles.
- Extremes: Cb=(127,127) and Cr=(-128,-128) -> o_c=127 then -128, with no wrap.
- FILTER_EN=0: Cb=(5,9), Cr=(7,-7) -> o_c=5 then 7.
- Odd-length line of 3 pixels, third pixel Y=50, Cb=-20, then de low -> third output has o_y=50, o_c=-20, sel=0, followed by a new line whose first pixel has sel=0.
- Reset asserted while S1 holds an even pixel -> no output pixel is emitted for it, and outputs are 0 on the next cycle.

Source files
------------

// File: rtl/csc_yuv444_to_422_if.sv
// Video bus for the 4:4:4 -> 4:2:2 chroma subsampler.
// The master side drives the 4:4:4 pixel stream and timing; the slave side
// (the subsampler) returns the 4:2:2 stream and delayed timing.
// Streaming contract: there is no backpressure. i_de high marks exactly one
// valid pixel per cycle, and o_de high marks exactly one valid output sample
// per cycle. The slave must accept every cycle and cannot stall.
interface csc_yuv444_to_422_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  i_vs;
  logic                  i_hs;
  logic                  i_de;
  logic [DATA_WIDTH-1:0] i_y;
  logic [DATA_WIDTH-1:0] i_cb;
  logic [DATA_WIDTH-1:0] i_cr;
  logic                  o_vs;
  logic                  o_hs;
  logic                  o_de;
  logic [DATA_WIDTH-1:0] o_y;
  logic [DATA_WIDTH-1:0] o_c;
  logic                  o_c_sel;

  modport master (
    output i_vs, i_hs, i_de, i_y, i_cb, i_cr,
    input  o_vs, o_hs, o_de, o_y, o_c, o_c_sel
  );

  modport slave (
    input  i_vs, i_hs, i_de, i_y, i_cb, i_cr,
    output o_vs, o_hs, o_de, o_y, o_c, o_c_sel
  );
endinterface

// File: rtl/csc_yuv444_to_422.sv
// YCbCr 4:4:4 -> 4:2:2 horizontal chroma subsampler.
// Pixels are paired within each de-high run. The even pixel carries Cb and
// the odd pixel carries Cr. Chroma is either a rounded pair average or the
// even pixel's value. A trailing unpaired pixel is flushed with its own Cb.
// Every sample leaves two cycles after it enters, aligned with the 2-deep
// vs/hs/de delay line.
module csc_yuv444_to_422 #(
  parameter int DATA_WIDTH = 8,
  parameter bit FILTER_EN  = 1'b1
) (
  input logic                 clk,
  input logic                 rstn,
  csc_yuv444_to_422_if.slave  bus
);

  // Rounded average of two signed samples. The sum is one bit wider, so it
  // cannot overflow. The result is floor((a + b + 1) / 2).
  function automatic logic [DATA_WIDTH-1:0] avg2(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH:0] s;
    s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b} + {{DATA_WIDTH{1'b0}}, 1'b1};
    return s[DATA_WIDTH:1];
  endfunction

  // Timing delay line
  logic vs1_q, vs1_d, hs1_q, hs1_d, de1_q, de1_d;
  logic vs2_q, vs2_d, hs2_q, hs2_d, de2_q, de2_d;

  // Pairing state: phase, S1 pending pixel, held odd-pixel Cr
  logic                  phase_q, phase_d;
  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_y_q, s1_y_d;
  logic [DATA_WIDTH-1:0] s1_cb_q, s1_cb_d;
  logic [DATA_WIDTH-1:0] s1_cr_q, s1_cr_d;
  logic                  cr_pend_q, cr_pend_d;
  logic [DATA_WIDTH-1:0] cr_hold_q, cr_hold_d;

  // Output data registers
  logic [DATA_WIDTH-1:0] out_y_q, out_y_d;
  logic [DATA_WIDTH-1:0] out_c_q, out_c_d;
  logic                  out_sel_q, out_sel_d;

  logic [DATA_WIDTH-1:0] cb_pair;
  logic [DATA_WIDTH-1:0] cr_pair;

  assign cb_pair = FILTER_EN ? avg2(s1_cb_q, bus.i_cb) : s1_cb_q;
  assign cr_pair = FILTER_EN ? avg2(s1_cr_q, bus.i_cr) : s1_cr_q;

  // Next-state logic: phase tracking, even capture, pair emission and flush
  always_comb begin
    vs1_d      = bus.i_vs;
    hs1_d      = bus.i_hs;
    de1_d      = bus.i_de;
    vs2_d      = vs1_q;
    hs2_d      = hs1_q;
    de2_d      = de1_q;
    phase_d    = phase_q;
    s1_valid_d = s1_valid_q;
    s1_y_d     = s1_y_q;
    s1_cb_d    = s1_cb_q;
    s1_cr_d    = s1_cr_q;
    cr_pend_d  = cr_pend_q;
    cr_hold_d  = cr_hold_q;
    out_y_d    = out_y_q;
    out_c_d    = out_c_q;
    out_sel_d  = out_sel_q;

    // The odd pixel of the previous pair goes out now. This never coincides
    // with a pair emission or a flush, because phase is even and S1 is not
    // pending in this cycle.
    if (cr_pend_q) begin
      out_y_d   = s1_y_q;
      out_c_d   = cr_hold_q;
      out_sel_d = 1'b1;
      cr_pend_d = 1'b0;
    end

    if (bus.i_de) begin
      if (!phase_q) begin
        s1_y_d     = bus.i_y;
        s1_cb_d    = bus.i_cb;
        s1_cr_d    = bus.i_cr;
        s1_valid_d = 1'b1;
        phase_d    = 1'b1;
      end else begin
        out_y_d    = s1_y_q;
        out_c_d    = cb_pair;
        out_sel_d  = 1'b0;
        s1_y_d     = bus.i_y;
        cr_hold_d  = cr_pair;
        s1_valid_d = 1'b0;
        cr_pend_d  = 1'b1;
        phase_d    = 1'b0;
      end
    end else begin
      phase_d = 1'b0;
      // Odd-length run: emit the orphan even pixel with its own Cb
      if (s1_valid_q) begin
        out_y_d    = s1_y_q;
        out_c_d    = s1_cb_q;
        out_sel_d  = 1'b0;
        s1_valid_d = 1'b0;
      end
    end
  end

  // State registers with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vs1_q      <= 1'b0;
      hs1_q      <= 1'b0;
      de1_q      <= 1'b0;
      vs2_q      <= 1'b0;
      hs2_q      <= 1'b0;
      de2_q      <= 1'b0;
      phase_q    <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_y_q     <= '0;
      s1_cb_q    <= '0;
      s1_cr_q    <= '0;
      cr_pend_q  <= 1'b0;
      cr_hold_q  <= '0;
      out_y_q    <= '0;
      out_c_q    <= '0;
      out_sel_q  <= 1'b0;
    end else begin
      vs1_q      <= vs1_d;
      hs1_q      <= hs1_d;
      de1_q      <= de1_d;
      vs2_q      <= vs2_d;
      hs2_q      <= hs2_d;
      de2_q      <= de2_d;
      phase_q    <= phase_d;
      s1_valid_q <= s1_valid_d;
      s1_y_q     <= s1_y_d;
      s1_cb_q    <= s1_cb_d;
      s1_cr_q    <= s1_cr_d;
      cr_pend_q  <= cr_pend_d;
      cr_hold_q  <= cr_hold_d;
      out_y_q    <= out_y_d;
      out_c_q    <= out_c_d;
      out_sel_q  <= out_sel_d;
    end
  end

  assign bus.o_vs    = vs2_q;
  assign bus.o_hs    = hs2_q;
  assign bus.o_de    = de2_q;
  assign bus.o_y     = out_y_q;
  assign bus.o_c     = out_c_q;
  assign bus.o_c_sel = out_sel_q;

endmodule

// File: tb/tb_csc_yuv444_to_422.sv
// Bench for csc_yuv444_to_422. Two instances share one stimulus stream:
// dut_f averages chroma and dut_d decimates it. The reference model works on
// whole de runs. Each pixel's position in its run decides what it emits.
module tb_csc_yuv444_to_422;
  localparam int W  = 8;
  localparam int PW = 2 * W + 4;

  // Clock and reset
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  csc_yuv444_to_422_if #(.DATA_WIDTH(W)) bus_f ();
  csc_yuv444_to_422_if #(.DATA_WIDTH(W)) bus_d ();

  csc_yuv444_to_422 #(.DATA_WIDTH(W), .FILTER_EN(1'b1)) dut_f (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_f)
  );

  csc_yuv444_to_422 #(.DATA_WIDTH(W), .FILTER_EN(1'b0)) dut_d (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_d)
  );

  int errors = 0;
  int checks = 0;

  // Scoreboard: one expected packed output {vs,hs,de,y,c,sel} per cycle
  logic [PW-1:0] exp_f_q[$];
  logic [PW-1:0] exp_d_q[$];

  // Model state: the previous input cycle (t-1), the Cr of t-2, and held data
  logic          m_de1 = 1'b0;
  logic          m_vs1 = 1'b0;
  logic          m_hs1 = 1'b0;
  int            m_k1  = 0;
  int            m_y1  = 0;
  int            m_cb1 = 0;
  int            m_cr1 = 0;
  int            m_cr2 = 0;
  logic [W-1:0]  hold_y  = '0;
  logic [W-1:0]  hold_cf = '0;
  logic [W-1:0]  hold_cd = '0;
  logic          hold_sel = 1'b0;

  function automatic int sx(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic logic [W-1:0] trunc(input int v);
    return v[W-1:0];
  endfunction

  // Rounded average; >>> on int gives floor division for negative sums
  function automatic int avg_ref(input int a, input int b);
    return (a + b + 1) >>> 1;
  endfunction

  // Driver: apply one cycle of inputs to both DUTs, step the model, then
  // settle to 1 time unit after the edge for sampling.
  task automatic drive_cycle(input logic rst_n, input logic vs, input logic hs,
                             input logic de, input logic [W-1:0] y,
                             input logic [W-1:0] cb, input logic [W-1:0] cr);
    int cur_k;
    rstn       = rst_n;
    bus_f.i_vs = vs;  bus_f.i_hs = hs;  bus_f.i_de = de;
    bus_f.i_y  = y;   bus_f.i_cb = cb;  bus_f.i_cr = cr;
    bus_d.i_vs = vs;  bus_d.i_hs = hs;  bus_d.i_de = de;
    bus_d.i_y  = y;   bus_d.i_cb = cb;  bus_d.i_cr = cr;
    @(posedge clk);
    if (!rst_n) begin
      m_de1 = 1'b0;  m_vs1 = 1'b0;  m_hs1 = 1'b0;  m_k1 = 0;
      hold_y = '0;  hold_cf = '0;  hold_cd = '0;  hold_sel = 1'b0;
      exp_f_q.push_back('0);
      exp_d_q.push_back('0);
    end else begin
      cur_k = de ? (m_de1 ? m_k1 + 1 : 0) : 0;
      if (m_de1) begin
        hold_y = trunc(m_y1);
        if ((m_k1 % 2) == 0) begin
          hold_sel = 1'b0;
          hold_cd  = trunc(m_cb1);
          hold_cf  = de ? trunc(avg_ref(m_cb1, sx(cb))) : trunc(m_cb1);
        end else begin
          hold_sel = 1'b1;
          hold_cd  = trunc(m_cr2);
          hold_cf  = trunc(avg_ref(m_cr2, m_cr1));
        end
      end
      exp_f_q.push_back({m_vs1, m_hs1, m_de1, hold_y, hold_cf, hold_sel});
      exp_d_q.push_back({m_vs1, m_hs1, m_de1, hold_y, hold_cd, hold_sel});
      m_cr2 = m_cr1;
      m_de1 = de;  m_vs1 = vs;  m_hs1 = hs;  m_k1 = cur_k;
      m_y1  = int'(y);  m_cb1 = sx(cb);  m_cr1 = sx(cr);
    end
    #1;
  endtask

  // Reset with random inputs, then a 4-pixel line
  task automatic test_reset();
    logic [PW-1:0] ef, ed, af, ad;
    for (int i = 0; i < 9; i++) begin
      if (i < 3)
        drive_cycle(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), W'($urandom),
                    W'($urandom), W'($urandom));
      else
        drive_cycle(1'b1, 1'b0, 1'b0, (i >= 4 && i < 8), W'($urandom),
                    W'($urandom), W'($urandom));
      ef = exp_f_q.pop_front();  ed = exp_d_q.pop_front();
      af = {bus_f.o_vs, bus_f.o_hs, bus_f.o_de, bus_f.o_y, bus_f.o_c, bus_f.o_c_sel};
      ad = {bus_d.o_vs, bus_d.o_hs, bus_d.o_de, bus_d.o_y, bus_d.o_c, bus_d.o_c_sel};
      checks++;
      if (af !== ef) begin errors++; $display("FAIL reset_f[%0d]: got %h want %h", i, af, ef); end
      checks++;
      if (ad !== ed) begin errors++; $display("FAIL reset_d[%0d]: got %h want %h", i, ad, ed); end
      if (i < 3) begin
        checks++;
        if (af !== '0) begin errors++; $display("FAIL reset_zero[%0d]: got %h want 0", i, af); end
      end
      if (i == 5) begin
        checks++;
        if ({bus_f.o_de, bus_f.o_c_sel} !== 2'b10) begin
          errors++;
          $display("FAIL reset_first_sel: de/sel got %b%b want 10", bus_f.o_de, bus_f.o_c_sel);
        end
      end
    end
  endtask

  // Directed pair: y, cb, cr of the even then odd pixel, and the literal
  // expected outputs on each DUT for the even and odd output cycles
  task automatic test_pair(input string name, input logic [W-1:0] y0, input logic [W-1:0] y1,
                           input logic [W-1:0] cb0, input logic [W-1:0] cb1,
                           input logic [W-1:0] cr0, input logic [W-1:0] cr1,
                           input logic [W-1:0] cf_even, input logic [W-1:0] cf_odd,
                           input logic [W-1:0] cd_even, input logic [W-1:0] cd_odd);
    logic [PW-1:0] ef, ed, af, ad;
    for (int i = 0; i < 5; i++) begin
      if (i == 1)      drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, y0, cb0, cr0);
      else if (i == 2) drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, y1, cb1, cr1);
      else             drive_cycle(1'b1, 1'b0, (i == 4), 1'b0, '0, '0, '0);
      ef = exp_f_q.pop_front();  ed = exp_d_q.pop_front();
      af = {bus_f.o_vs, bus_f.o_hs, bus_f.o_de, bus_f.o_y, bus_f.o_c, bus_f.o_c_sel};
      ad = {bus_d.o_vs, bus_d.o_hs, bus_d.o_de, bus_d.o_y, bus_d.o_c, bus_d.o_c_sel};
      checks++;
      if (af !== ef) begin errors++; $display("FAIL %s_f[%0d]: got %h want %h", name, i, af, ef); end
      checks++;
      if (ad !== ed) begin errors++; $display("FAIL %s_d[%0d]: got %h want %h", name, i, ad, ed); end
      if (i == 2 || i == 3) begin
        checks++;
        if ({bus_f.o_de, bus_f.o_y, bus_f.o_c, bus_f.o_c_sel} !==
            {1'b1, (i == 2) ? y0 : y1, (i == 2) ? cf_even : cf_odd, (i == 3)}) begin
          errors++;
          $display("FAIL %s_lit_f[%0d]: got de=%b y=%0d c=%h sel=%b", name, i,
                   bus_f.o_de, bus_f.o_y, bus_f.o_c, bus_f.o_c_sel);
        end
        checks++;
        if ({bus_d.o_de, bus_d.o_y, bus_d.o_c, bus_d.o_c_sel} !==
            {1'b1, (i == 2) ? y0 : y1, (i == 2) ? cd_even : cd_odd, (i == 3)}) begin
          errors++;
          $display("FAIL %s_lit_d[%0d]: got de=%b y=%0d c=%h sel=%b", name, i,
                   bus_d.o_de, bus_d.o_y, bus_d.o_c, bus_d.o_c_sel);
        end
      end
    end
  endtask

  // Odd-length line of 3, one de-low cycle, then a new 2-pixel line
  task automatic test_odd_line();
    logic [PW-1:0] ef, ed, af, ad;
    logic          de;
    for (int i = 0; i < 9; i++) begin
      de = (i >= 1 && i <= 3) || (i == 5 || i == 6);
      if (i == 3) drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'd50, 8'hEC, W'($urandom));
      else        drive_cycle(1'b1, 1'b0, 1'b0, de, W'($urandom), W'($urandom), W'($urandom));
      ef = exp_f_q.pop_front();  ed = exp_d_q.pop_front();
      af = {bus_f.o_vs, bus_f.o_hs, bus_f.o_de, bus_f.o_y, bus_f.o_c, bus_f.o_c_sel};
      ad = {bus_d.o_vs, bus_d.o_hs, bus_d.o_de, bus_d.o_y, bus_d.o_c, bus_d.o_c_sel};
      checks++;
      if (af !== ef) begin errors++; $display("FAIL odd_f[%0d]: got %h want %h", i, af, ef); end
      checks++;
      if (ad !== ed) begin errors++; $display("FAIL odd_d[%0d]: got %h want %h", i, ad, ed); end
      if (i == 4) begin
        checks++;
        if ({bus_f.o_de, bus_f.o_y, bus_f.o_c, bus_f.o_c_sel} !== {1'b1, 8'd50, 8'hEC, 1'b0}) begin
          errors++;
          $display("FAIL odd_flush: got de=%b y=%0d c=%h sel=%b want 1 50 ec 0",
                   bus_f.o_de, bus_f.o_y, bus_f.o_c, bus_f.o_c_sel);
        end
      end
      if (i == 6) begin
        checks++;
        if ({bus_f.o_de, bus_f.o_c_sel} !== 2'b10) begin
          errors++;
          $display("FAIL odd_next_line: de/sel got %b%b want 10", bus_f.o_de, bus_f.o_c_sel);
        end
      end
    end
  endtask

  // Reset asserted while an even pixel is pending in S1
  task automatic test_reset_pending();
    logic [PW-1:0] ef, ed, af, ad;
    for (int i = 0; i < 5; i++) begin
      drive_cycle((i != 2), 1'b1, 1'b1, (i == 1 || i == 2), 8'd77, 8'd33, 8'd44);
      ef = exp_f_q.pop_front();  ed = exp_d_q.pop_front();
      af = {bus_f.o_vs, bus_f.o_hs, bus_f.o_de, bus_f.o_y, bus_f.o_c, bus_f.o_c_sel};
      ad = {bus_d.o_vs, bus_d.o_hs, bus_d.o_de, bus_d.o_y, bus_d.o_c, bus_d.o_c_sel};
      checks++;
      if (af !== ef) begin errors++; $display("FAIL rstpend_f[%0d]: got %h want %h", i, af, ef); end
      checks++;
      if (ad !== ed) begin errors++; $display("FAIL rstpend_d[%0d]: got %h want %h", i, ad, ed); end
      if (i == 2 || i == 3) begin
        checks++;
        if ({af[PW-3:0], ad[PW-3:0]} !== '0) begin
          errors++;
          $display("FAIL rstpend_zero[%0d]: got f=%h d=%h want 0", i, af, ad);
        end
      end
    end
  endtask

  // Random lines with gaps of 1..3 cycles, including single-cycle gaps
  task automatic test_back_to_back();
    logic [PW-1:0] ef, ed, af, ad;
    int            len, gap;
    for (int ln = 0; ln < 40; ln++) begin
      len = $urandom_range(1, 9);
      gap = (ln % 3 == 0) ? 1 : $urandom_range(1, 3);
      for (int c = 0; c < len + gap; c++) begin
        drive_cycle(1'b1, (ln % 8 == 0) && (c >= len), (c == len), (c < len),
                    W'($urandom), W'($urandom), W'($urandom));
        ef = exp_f_q.pop_front();  ed = exp_d_q.pop_front();
        af = {bus_f.o_vs, bus_f.o_hs, bus_f.o_de, bus_f.o_y, bus_f.o_c, bus_f.o_c_sel};
        ad = {bus_d.o_vs, bus_d.o_hs, bus_d.o_de, bus_d.o_y, bus_d.o_c, bus_d.o_c_sel};
        checks++;
        if (af !== ef) begin errors++; $display("FAIL b2b_f[%0d.%0d]: got %h want %h", ln, c, af, ef); end
        checks++;
        if (ad !== ed) begin errors++; $display("FAIL b2b_d[%0d.%0d]: got %h want %h", ln, c, ad, ed); end
      end
    end
  endtask

  initial begin
    test_reset();
    // Averaging: Cb (-3,-4) -> -3, Cr (100,101) -> 101; decimation gives -3, 100
    test_pair("avg", 8'd10, 8'd20, 8'hFD, 8'hFC, 8'd100, 8'd101,
              8'hFD, 8'd101, 8'hFD, 8'd100);
    // Extremes: Cb (127,127) -> 127, Cr (-128,-128) -> -128 without wrap
    test_pair("ext", 8'd200, 8'd255, 8'h7F, 8'h7F, 8'h80, 8'h80,
              8'h7F, 8'h80, 8'h7F, 8'h80);
    // Decimation: Cb (5,9), Cr (7,-7) -> 5 then 7; averaging gives 7 then 0
    test_pair("dec", 8'd1, 8'd2, 8'd5, 8'd9, 8'd7, 8'hF9,
              8'd7, 8'd0, 8'd5, 8'd7);
    test_odd_line();
    test_reset_pending();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
